uart_mmio: RTL

- Memory-mapped 8N1 UART that sits directly downstream of the cpu's data bus.
- Decodes the UART data address (0x01e) and a status address (0x01c).
- CPU stores to 0x01e are queued in a TX FIFO and serialized onto `tx`.
- Bytes received on `rx` are held in a one-byte buffer that the CPU reads at 0x01e.
- Its `rd_data` is muxed ahead of the BRAM read data in the top level.

---
 rtl/uart_mmio.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on the CPU data bus.
//   0x01e DATA   : write queues a byte for transmit, read returns the receive buffer
//   0x01c STATUS : {tx_overflow, rx_overrun, rx_valid, tx_empty, tx_full}
// Optional feature macro: UART_MMIO_LOOPBACK_EN feeds the registered tx back into the
// receiver in place of the rx pin.
module uart_mmio #(
    parameter int CLOCK_HZ   = 100_000,
    parameter int BAUD       = 10_000,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  byt,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data,
    output logic                  hit,
    output logic                  tx,
    input  logic                  rx
);

    localparam int DIV   = CLOCK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0]      DIV_LAST    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]      HALF_LAST   = CNT_W'(DIV / 2 - 1);
    localparam logic [PTR_W:0]        FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DATA_ADDR   = ADDR_WIDTH'(10'h01e);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(10'h01c);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // Byte width is irrelevant: both access sizes use the low data byte.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, byt, wr_data[15:8]};

    // ---------------- bus decode ----------------
    logic data_sel, status_sel;
    logic push_req, rx_rd_clr, status_wr;
    assign data_sel   = (addr == DATA_ADDR);
    assign status_sel = (addr == STATUS_ADDR);
    assign hit        = data_sel | status_sel;
    assign push_req   = wr & data_sel;
    assign rx_rd_clr  = rd & data_sel;
    assign status_wr  = wr & status_sel;

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [7:0]       head_reg;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             fifo_empty, tx_full, pop, push_ok;

    assign fifo_empty = (count_reg == '0);
    assign tx_full    = (count_reg == FIFO_FULL);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req & (~tx_full | pop);

    // FIFO storage with a registered read port; head_reg only changes on a pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= wr_data[7:0];
        end
        if (pop) begin
            head_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(push_ok);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // ---------------- TX serializer ----------------
    tx_state_t        tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_baud_reg, tx_baud_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             tx_reg, tx_next;
    logic             tx_overflow_reg, tx_overflow_next;
    logic             tx_empty;

    assign tx_empty = fifo_empty & (tx_state_reg == T_IDLE);
    assign tx       = tx_reg;

    // TX next-state: the head byte is taken into the shifter as the start bit ends,
    // which gives the registered FIFO read a full bit time to settle.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_baud_next  = tx_baud_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        pop           = 1'b0;
        unique case (tx_state_reg)
            T_IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    tx_baud_next  = '0;
                    tx_state_next = T_START;
                end
            end
            T_START: begin
                if (tx_baud_reg == DIV_LAST) begin
                    tx_baud_next  = '0;
                    tx_bit_next   = '0;
                    tx_shift_next = head_reg;
                    tx_state_next = T_DATA;
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            T_DATA: begin
                if (tx_baud_reg == DIV_LAST) begin
                    tx_baud_next  = '0;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = T_STOP;
                    end
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            T_STOP: begin
                if (tx_baud_reg == DIV_LAST) begin
                    tx_baud_next  = '0;
                    tx_state_next = T_IDLE;
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            default: tx_state_next = T_IDLE;
        endcase

        // Line level follows the current state one cycle later (glitch-free output).
        unique case (tx_state_reg)
            T_START: tx_next = 1'b0;
            T_DATA:  tx_next = tx_shift_reg[0];
            default: tx_next = 1'b1;
        endcase

        tx_overflow_next = tx_overflow_reg;
        if (status_wr && wr_data[4]) begin
            tx_overflow_next = 1'b0;
        end
        if (push_req && !push_ok) begin
            tx_overflow_next = 1'b1;
        end
    end

    // ---------------- RX path ----------------
    logic rx_in;
`ifdef UART_MMIO_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = rx;
    assign rx_in     = tx_reg;
`else
    assign rx_in = rx;
`endif

    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_baud_reg, rx_baud_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic [7:0]       rx_byte_reg, rx_byte_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             rx_overrun_reg, rx_overrun_next;
    logic             sync1_reg, sync2_reg;
    logic             rx_done;

    // RX next-state: sample at bit centres, then hand a good byte to the buffer.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_baud_next  = rx_baud_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        unique case (rx_state_reg)
            R_IDLE: begin
                if (!sync2_reg) begin
                    rx_baud_next  = '0;
                    rx_state_next = R_START;
                end
            end
            R_START: begin
                if (rx_baud_reg == HALF_LAST) begin
                    rx_baud_next  = '0;
                    rx_bit_next   = '0;
                    // Line already back high at mid-start: a glitch, not a frame.
                    rx_state_next = sync2_reg ? R_IDLE : R_DATA;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_baud_reg == DIV_LAST) begin
                    rx_baud_next  = '0;
                    rx_shift_next = {sync2_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = R_STOP;
                    end
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            R_STOP: begin
                if (rx_baud_reg == DIV_LAST) begin
                    rx_baud_next  = '0;
                    rx_done       = sync2_reg;   // low stop bit: framing error, drop silently
                    rx_state_next = R_IDLE;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    // Receive buffer: a byte arriving while the old one is unread is lost unless
    // the CPU is consuming the old one in that very cycle.
    always_comb begin
        rx_byte_next    = rx_byte_reg;
        rx_valid_next   = rx_valid_reg;
        rx_overrun_next = rx_overrun_reg;
        if (status_wr && wr_data[3]) begin
            rx_overrun_next = 1'b0;
        end
        if (rx_done) begin
            if (!rx_valid_reg || rx_rd_clr) begin
                rx_byte_next  = rx_shift_reg;
                rx_valid_next = 1'b1;
            end else begin
                rx_overrun_next = 1'b1;
            end
        end else if (rx_rd_clr) begin
            rx_valid_next = 1'b0;
        end
    end

    // All control state, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            tx_state_reg    <= T_IDLE;
            tx_baud_reg     <= '0;
            tx_bit_reg      <= '0;
            tx_shift_reg    <= '0;
            tx_reg          <= 1'b1;
            tx_overflow_reg <= 1'b0;
            sync1_reg       <= 1'b1;
            sync2_reg       <= 1'b1;
            rx_state_reg    <= R_IDLE;
            rx_baud_reg     <= '0;
            rx_bit_reg      <= '0;
            rx_shift_reg    <= '0;
            rx_byte_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            rx_overrun_reg  <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            tx_state_reg    <= tx_state_next;
            tx_baud_reg     <= tx_baud_next;
            tx_bit_reg      <= tx_bit_next;
            tx_shift_reg    <= tx_shift_next;
            tx_reg          <= tx_next;
            tx_overflow_reg <= tx_overflow_next;
            sync1_reg       <= rx_in;
            sync2_reg       <= sync1_reg;
            rx_state_reg    <= rx_state_next;
            rx_baud_reg     <= rx_baud_next;
            rx_bit_reg      <= rx_bit_next;
            rx_shift_reg    <= rx_shift_next;
            rx_byte_reg     <= rx_byte_next;
            rx_valid_reg    <= rx_valid_next;
            rx_overrun_reg  <= rx_overrun_next;
        end
    end

    // Read mux: combinational from addr, zero when not addressed.
    always_comb begin
        rd_data = 16'h0000;
        if (status_sel) begin
            rd_data = {11'b0, tx_overflow_reg, rx_overrun_reg, rx_valid_reg, tx_empty, tx_full};
        end else if (data_sel) begin
            rd_data = {8'h00, rx_byte_reg};
        end
    end

endmodule
